grng_sample_compactor: RTL and testbench
========================================

// Module: grng_sample_compactor
// PURPOSE
//  Multi-lane output collector for LANES parallel Ziggurat GRNG pipelines (Stage1..Stage5 chains).
//  Discards rejected samples and packs the accepted ones, in lane order, into a FIFO.
//  Delivers them on one valid/ready stream and keeps running total/reject statistics.
//  Throttles the pipelines' valid_in so that in-flight samples never overflow the FIFO.
// PARAMETERS
//  LANES      2   number of parallel GRNG pipelines (1..8)
//  WIDTH      36  sample width, signed Q8.28 (matches Stage5 value)
//  DEPTH      32  FIFO entries; power of 2; must exceed HEADROOM (elaboration check, $fatal)
//  PIPE_DEPTH 5   cycles from GRNG valid_in to valid_out
//  CNT_W      32  statistics counter width
//  HEADROOM   = LANES*(PIPE_DEPTH+1), derived localparam
// PORTS
//  clk          in   1             clock, all state on rising edge
//  rst          in   1             asynchronous reset, active-high
//  enable       in   1             run request for the generators
//  clear_counts in   1             synchronous clear of counters and overflow
//  in_valid     in   LANES         per-lane Stage5 valid_out
//  in_reject    in   LANES         per-lane Stage5 reject_out
//  in_value     in   LANES*WIDTH   per-lane value; lane i at [i*WIDTH +: WIDTH]
//  gen_valid    out  1             drives valid_in of every lane's Stage1
//  out_valid    out  1             head sample available
//  out_ready    in   1             consumer accepts head sample
//  out_value    out  WIDTH         head sample (show-ahead)
//  count_total  out  CNT_W         samples seen (valid, rejected or not)
//  count_reject out  CNT_W         rejected samples seen
//  overflow     out  1             sticky: an accepted sample was dropped
// BEHAVIOUR
//  Reset (async): rd/wr pointers, occupancy, gen_valid, counters and overflow all go to 0.
//   out_valid=0. FIFO contents are don't-care. Reset mid-stream discards everything in flight.
//  Accept mask per cycle: acc = in_valid & ~in_reject. k = popcount(acc), 0..LANES.
//  Push: accepted lanes are written in ascending lane index to wr_ptr, wr_ptr+1, ...
//   Pointers wrap modulo DEPTH. Written data is visible at out_value no earlier than the next cycle.
//  Pop: pop = out_valid & out_ready. rd_ptr advances by 1.
//  out_valid = (occupancy != 0). out_value = mem[rd_ptr].
//   out_value holds stable while out_valid & ~out_ready.
//  Occupancy next = occupancy + written - pop. Same-cycle push and pop on a full FIFO is legal.
//   Free space for that cycle = DEPTH - occupancy + pop.
//  Overflow: if k > free space, only the lowest-lane accepted samples fitting the free space are written.
//   The rest are dropped and overflow is set. Never corrupts pointers.
//  gen_valid is a register: next = enable & ((DEPTH - occupancy_next) >= HEADROOM).
//   With this throttle, overflow cannot occur unless the throttle is bypassed upstream.
//  Counters: count_total += popcount(in_valid). count_reject += popcount(in_valid & in_reject).
//   Both saturate at 2^CNT_W-1; they never wrap.
//   in_reject is ignored on lanes where in_valid=0.
//  clear_counts: next cycle both counters = 0 and overflow = 0.
//   Clear has priority: that cycle's samples are not counted, but are still pushed.
//   FIFO is unaffected.
//  Invariant: count_total - count_reject = pushed + dropped.
// TESTING
//  T1 reset: rst pulse mid-stream with occupancy 7
//     -> out_valid=0, gen_valid=0, counters=0 asynchronously; first push after release appears at rd_ptr 0.
//  T2 compaction: one cycle, LANES=2, lane0 reject=1, lane1 value=36'h0_1000_0000 accepted
//     -> exactly one entry 36'h010000000; count_total+=2, count_reject+=1.
//  T3 ordering: lane0=A, lane1=B accepted, then next cycle lane1 only=C
//     -> out_value sequence A,B,C with out_ready=1; out_valid falls after C.
//  T4 throttle: enable=1, out_ready=0, all lanes always accepted
//     -> gen_valid drops when free < 12; occupancy peaks <= 32; overflow stays 0.
//  T5 overflow: bypass throttle, fill to 31, push 2 with no pop
//     -> lane0 stored, lane1 dropped, overflow=1; same case with out_ready=1 stores both.
//  T6 saturation/clear: CNT_W=4, 20 valid samples -> count_total=15 held;
//     clear_counts with a valid input -> counters 0 next cycle, FIFO still receives that sample.

Source files
------------

// File: rtl/grng_sample_compactor.sv
// Collects accepted Ziggurat GRNG samples from parallel lanes into one FIFO stream,
// keeps saturating statistics and throttles the generators to protect FIFO space.
module grng_sample_compactor #(
    parameter int LANES      = 2,
    parameter int WIDTH      = 36,
    parameter int DEPTH      = 32,
    parameter int PIPE_DEPTH = 5,
    parameter int CNT_W      = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic                   clear_counts,
    input  logic [LANES-1:0]       in_valid,
    input  logic [LANES-1:0]       in_reject,
    input  logic [LANES*WIDTH-1:0] in_value,
    output logic                   gen_valid,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_value,
    output logic [CNT_W-1:0]       count_total,
    output logic [CNT_W-1:0]       count_reject,
    output logic                   overflow
);
    localparam int HEADROOM = LANES * (PIPE_DEPTH + 1);
    localparam int AW = $clog2(DEPTH);
    localparam int OW = AW + 1;
    localparam int SW = CNT_W + OW;

    if (LANES < 1 || LANES > 8 || DEPTH <= HEADROOM || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_cfg
        $fatal(1, "grng_sample_compactor: DEPTH must be a power of 2 above HEADROOM");
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [OW-1:0]    occ;

    logic [LANES-1:0] acc;
    logic [LANES-1:0] wr_en;
    logic [OW-1:0]    wr_off [LANES];
    logic [OW-1:0]    free;
    logic [OW-1:0]    seen;
    logic [OW-1:0]    nwr;
    logic [OW-1:0]    nval;
    logic [OW-1:0]    nrej;
    logic [OW-1:0]    occ_next;
    logic             pop;
    logic             drop;
    logic             gen_next;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [OW-1:0] b);
        logic [SW-1:0] s;
        s = SW'(a) + SW'(b);
        return (s > SW'({CNT_W{1'b1}})) ? {CNT_W{1'b1}} : s[CNT_W-1:0];
    endfunction

    assign out_valid = (occ != '0);
    assign out_value = mem[rd_ptr];

    always_comb begin
        acc   = in_valid & ~in_reject;
        pop   = out_valid & out_ready;
        free  = OW'(DEPTH) - occ + OW'(pop);
        seen  = '0;
        nwr   = '0;
        nval  = '0;
        nrej  = '0;
        wr_en = '0;
        for (int i = 0; i < LANES; i++) begin
            wr_off[i] = seen;
            if (in_valid[i]) nval = nval + OW'(1);
            if (in_valid[i] && in_reject[i]) nrej = nrej + OW'(1);
            // lanes are ranked in index order; only the lowest ones that fit get written
            if (acc[i]) begin
                if (seen < free) begin
                    wr_en[i] = 1'b1;
                    nwr = nwr + OW'(1);
                end
                seen = seen + OW'(1);
            end
        end
        drop     = (seen > free);
        occ_next = occ + nwr - OW'(pop);
        gen_next = enable && ((OW'(DEPTH) - occ_next) >= OW'(HEADROOM));
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (wr_en[i]) mem[wr_ptr + AW'(wr_off[i])] <= in_value[i*WIDTH +: WIDTH];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            occ          <= '0;
            gen_valid    <= 1'b0;
            count_total  <= '0;
            count_reject <= '0;
            overflow     <= 1'b0;
        end else begin
            wr_ptr    <= wr_ptr + AW'(nwr);
            occ       <= occ_next;
            gen_valid <= gen_next;
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            if (clear_counts) begin
                count_total  <= '0;
                count_reject <= '0;
                overflow     <= 1'b0;
            end else begin
                count_total  <= sat_add(count_total, nval);
                count_reject <= sat_add(count_reject, nrej);
                if (drop) overflow <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_grng_sample_compactor.sv
// Bench for grng_sample_compactor: queue model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_grng_sample_compactor;
    localparam int LANES = 2;
    localparam int WIDTH = 36;
    localparam int DEPTH = 32;
    localparam int HEADROOM = 12;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic enable = 1'b0;
    logic clear_counts = 1'b0;
    logic out_ready = 1'b0;
    logic [LANES-1:0] in_valid = '0;
    logic [LANES-1:0] in_reject = '0;
    logic [LANES*WIDTH-1:0] in_value = '0;

    logic gen_valid, out_valid, overflow;
    logic [WIDTH-1:0] out_value;
    logic [31:0] count_total, count_reject;
    logic gen_valid4, out_valid4, overflow4;
    logic [WIDTH-1:0] out_value4;
    logic [3:0] count_total4, count_reject4;

    int tests = 0;
    int fails = 0;

    grng_sample_compactor dut (
        .clk(clk), .rst(rst), .enable(enable), .clear_counts(clear_counts),
        .in_valid(in_valid), .in_reject(in_reject), .in_value(in_value),
        .gen_valid(gen_valid), .out_valid(out_valid), .out_ready(out_ready),
        .out_value(out_value), .count_total(count_total),
        .count_reject(count_reject), .overflow(overflow)
    );

    grng_sample_compactor #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .enable(enable), .clear_counts(clear_counts),
        .in_valid(in_valid), .in_reject(in_reject), .in_value(in_value),
        .gen_valid(gen_valid4), .out_valid(out_valid4), .out_ready(out_ready),
        .out_value(out_value4), .count_total(count_total4),
        .count_reject(count_reject4), .overflow(overflow4)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // behavioural model
    logic [WIDTH-1:0] q[$];
    longint m_tot = 0, m_rej = 0, m_tot4 = 0, m_rej4 = 0;
    bit m_ovf = 0, m_gv = 0;
    int max_occ = 0;

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            q.delete();
            m_tot = 0; m_rej = 0; m_tot4 = 0; m_rej4 = 0;
            m_ovf = 0; m_gv = 0;
        end else begin
            int free, seen, nv, nr;
            bit pop, drop;
            pop  = (q.size() != 0) && out_ready;
            free = DEPTH - q.size() + int'(pop);
            if (pop) void'(q.pop_front());
            seen = 0; nv = 0; nr = 0; drop = 0;
            for (int i = 0; i < LANES; i++) begin
                if (in_valid[i]) begin
                    nv++;
                    if (in_reject[i]) nr++;
                    else begin
                        if (seen < free) q.push_back(in_value[i*WIDTH +: WIDTH]);
                        else drop = 1;
                        seen++;
                    end
                end
            end
            if (clear_counts) begin
                m_tot = 0; m_rej = 0; m_tot4 = 0; m_rej4 = 0; m_ovf = 0;
            end else begin
                m_tot  = (m_tot + nv > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_tot + nv;
                m_rej  = (m_rej + nr > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_rej + nr;
                m_tot4 = (m_tot4 + nv > 15) ? 15 : m_tot4 + nv;
                m_rej4 = (m_rej4 + nr > 15) ? 15 : m_rej4 + nr;
                if (drop) m_ovf = 1;
            end
            m_gv = enable && ((DEPTH - q.size()) >= HEADROOM);
            if (q.size() > max_occ) max_occ = q.size();
        end
    end

    // per-cycle compare
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
            if (q.size() != 0) chk("out_value", 64'(out_value), 64'(q[0]));
            chk("gen_valid", 64'(gen_valid), 64'(m_gv));
            chk("count_total", 64'(count_total), 64'(m_tot));
            chk("count_reject", 64'(count_reject), 64'(m_rej));
            chk("overflow", 64'(overflow), 64'(m_ovf));
            chk("count_total4", 64'(count_total4), 64'(m_tot4));
            chk("count_reject4", 64'(count_reject4), 64'(m_rej4));
        end
    end

    task automatic step(input logic [1:0] v, input logic [1:0] r,
                        input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic rdy);
        @(negedge clk);
        #1;
        in_valid  = v;
        in_reject = r;
        in_value  = {b, a};
        out_ready = rdy;
    endtask

    task automatic drain(output int n);
        n = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            #1;
            if (q.size() == 0) break;
            in_valid  = '0;
            in_reject = '0;
            out_ready = 1'b1;
            n++;
        end
        chk("drain_bound", 64'(q.size()), 64'(0));
        in_valid  = '0;
        out_ready = 1'b0;
    endtask

    initial begin
        int n;
        bit hist[$];
        bit saw_drop;
        logic [WIDTH-1:0] seq;

        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        bit hist[$];
        bit saw_drop;
        logic [WIDTH-1:0] seq;

        repeat (2) @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_gen_valid", 64'(gen_valid), 64'(0));
        chk("rst_count_total", 64'(count_total), 64'(0));
        chk("rst_overflow", 64'(overflow), 64'(0));
        rst = 1'b0;

        // T2 compaction
        step(2'b11, 2'b01, 36'h0_dead_beef, 36'h0_1000_0000, 1'b0);
        step(2'b00, 2'b00, '0, '0, 1'b1);
        chk("t2_value", 64'(out_value), 64'h0_1000_0000);
        chk("t2_total", 64'(count_total), 64'd2);
        chk("t2_reject", 64'(count_reject), 64'd1);
        step(2'b00, 2'b00, '0, '0, 1'b0);
        chk("t2_single", 64'(out_valid), 64'(0));

        // T3 ordering
        step(2'b11, 2'b00, 36'h0_0000_000A, 36'h0_0000_000B, 1'b1);
        step(2'b10, 2'b00, '0, 36'h0_0000_000C, 1'b1);
        chk("t3_a", 64'(out_value), 64'hA);
        step(2'b00, 2'b00, '0, '0, 1'b1);
        chk("t3_b", 64'(out_value), 64'hB);
        step(2'b00, 2'b00, '0, '0, 1'b1);
        chk("t3_c", 64'(out_value), 64'hC);
        step(2'b00, 2'b00, '0, '0, 1'b0);
        chk("t3_empty", 64'(out_valid), 64'(0));

        // T1 reset mid-stream with occupancy 7
        enable = 1'b1;
        for (int i = 0; i < 7; i++) step(2'b01, 2'b00, 36'(100 + i), '0, 1'b0);
        step(2'b00, 2'b00, '0, '0, 1'b0);
        chk("t1_pre_gen", 64'(gen_valid), 64'(1));
        #2 rst = 1'b1;
        #1;
        chk("t1_out_valid", 64'(out_valid), 64'(0));
        chk("t1_gen_valid", 64'(gen_valid), 64'(0));
        chk("t1_total", 64'(count_total), 64'(0));
        chk("t1_reject", 64'(count_reject), 64'(0));
        @(negedge clk);
        #1 rst = 1'b0;
        step(2'b01, 2'b00, 36'h0_0000_0777, '0, 1'b0);
        step(2'b00, 2'b00, '0, '0, 1'b0);
        chk("t1_first_push", 64'(out_value), 64'h777);
        enable = 1'b0;
        drain(n);
        chk("t1_drain", 64'(n), 64'd1);

        // T4 throttle: upstream pipeline delays gen_valid by 5 cycles
        enable = 1'b1;
        max_occ = 0;
        saw_drop = 0;
        seq = 36'h1000;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            #1;
            if (c == 40) enable = 1'b0;
            hist.push_back(gen_valid);
            if (c > 5 && hist[c-1] && !gen_valid) saw_drop = 1;
            in_reject = '0;
            out_ready = 1'b0;
            if (c >= 5 && hist[c-5]) begin
                in_valid = 2'b11;
                in_value = {36'(seq + 1), seq};
                seq = seq + 2;
            end else begin
                in_valid = '0;
            end
        end
        step(2'b00, 2'b00, '0, '0, 1'b0);
        chk("t4_overflow", 64'(overflow), 64'(0));
        chk("t4_peak_ok", 64'(max_occ <= DEPTH), 64'(1));
        chk("t4_peak", 64'(max_occ), 64'(DEPTH));
        chk("t4_throttled", 64'(saw_drop), 64'(1));
        drain(n);

        // T5 overflow with throttle bypassed
        for (int i = 0; i < 15; i++) step(2'b11, 2'b00, 36'(2*i), 36'(2*i+1), 1'b0);
        step(2'b01, 2'b00, 36'd30, '0, 1'b0);
        step(2'b11, 2'b00, 36'h0_5555_0000, 36'h0_6666_0000, 1'b0);
        step(2'b00, 2'b00, '0, '0, 1'b0);
        chk("t5_overflow", 64'(overflow), 64'(1));
        clear_counts = 1'b1;
        step(2'b00, 2'b00, '0, '0, 1'b0);
        #1 clear_counts = 1'b0;
        step(2'b00, 2'b00, '0, '0, 1'b1);
        chk("t5_cleared", 64'(overflow), 64'(0));
        step(2'b11, 2'b00, 36'h0_7777_0000, 36'h0_8888_0000, 1'b1);
        step(2'b00, 2'b00, '0, '0, 1'b0);
        chk("t5_no_overflow", 64'(overflow), 64'(0));
        drain(n);
        chk("t5_drain", 64'(n), 64'(DEPTH));

        // T6 saturation and clear
        clear_counts = 1'b1;
        step(2'b00, 2'b00, '0, '0, 1'b0);
        #1 clear_counts = 1'b0;
        for (int i = 0; i < 10; i++) step(2'b11, 2'b00, 36'(200 + i), 36'(300 + i), 1'b1);
        step(2'b00, 2'b00, '0, '0, 1'b1);
        chk("t6_sat_total", 64'(count_total4), 64'd15);
        chk("t6_reject0", 64'(count_reject4), 64'd0);
        step(2'b11, 2'b11, '0, '0, 1'b1);
        step(2'b11, 2'b11, '0, '0, 1'b1);
        step(2'b00, 2'b00, '0, '0, 1'b1);
        chk("t6_held", 64'(count_total4), 64'd15);
        chk("t6_reject4", 64'(count_reject4), 64'd4);
        chk("t6_wide_total", 64'(count_total), 64'd24);
        drain(n);
        step(2'b01, 2'b00, 36'h0_ABCD_0123, '0, 1'b0);
        clear_counts = 1'b1;
        step(2'b00, 2'b00, '0, '0, 1'b0);
        clear_counts = 1'b0;
        chk("t6_clr_total4", 64'(count_total4), 64'd0);
        chk("t6_clr_total", 64'(count_total), 64'd0);
        chk("t6_clr_reject", 64'(count_reject), 64'd0);
        chk("t6_clr_valid", 64'(out_valid), 64'd1);
        chk("t6_clr_value", 64'(out_value), 64'h0_ABCD_0123);
        drain(n);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
